// File: rtl/led_count_sequencer.sv
// -----------------------------------------------------------------------------
// led_count_sequencer
//
// Four-bit LED counter driven by three push buttons. Each raw button is
// synchronised, debounced and turned into a one-cycle press event. A small
// IDLE / RUN / PAUSE state machine uses those events to run the counter
// freely (one step every TICK_DIV clocks), to single-step it, or to clear it.
//
// Optional feature (compile-time macro LED_SEQ_UPDOWN_EN):
//   defined   - the counter ping-pongs 0..15..0 using a direction register
//   undefined - the counter always increments modulo 16
//
// Parameters
//   TICK_DIV      clk cycles per count step while running (>= 2)
//   DEBOUNCE_CYC  stable cycles required before a button level is accepted (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   btn_run_n   in   raw run/pause button, active-low, asynchronous
//   btn_step_n  in   raw single-step button, active-low, asynchronous
//   btn_clr_n   in   raw clear button, active-low, asynchronous
//   led         out  current count value (registered)
//   running     out  high while the state machine is in RUN (registered)
//   tick        out  one-cycle pulse marking a running count step (registered)
// -----------------------------------------------------------------------------
module led_count_sequencer #(
  parameter int TICK_DIV     = 12000000,
  parameter int DEBOUNCE_CYC = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_n,
  input  logic       btn_step_n,
  input  logic       btn_clr_n,
  output logic [3:0] led,
  output logic       running,
  output logic       tick
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

  // Button indices inside the packed vectors below.
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_CLR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button front end: synchroniser, inversion, debounce, press detection
  // ---------------------------------------------------------------------------
  logic [2:0] sync_a_r;   // first synchroniser stage (raw polarity)
  logic [2:0] sync_b_r;   // second synchroniser stage (raw polarity)
  logic [2:0] btn_lvl_s;  // synchronised, active-high level
  logic [2:0] press_s;    // one-cycle press events
  logic [1:0] flush_r;    // counts synchroniser fill after reset
  logic       flushed_s;  // synchroniser now holds real post-reset samples

  // Two-flop synchroniser; reset value is the released (high) raw level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_r <= 3'b111;
      sync_b_r <= 3'b111;
    end else begin
      sync_a_r <= {btn_clr_n, btn_step_n, btn_run_n};
      sync_b_r <= sync_a_r;
    end
  end

  assign btn_lvl_s = ~sync_b_r;

  // Track when the synchroniser output stops reflecting its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_r <= 2'd0;
    end else if (!flushed_s) begin
      flush_r <= flush_r + 2'd1;
    end else begin
      flush_r <= flush_r;
    end
  end

  assign flushed_s = (flush_r == 2'd2);

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [DW-1:0] cnt_r;    // consecutive cycles the level has disagreed
    logic          deb_r;    // debounced level, 1 = pressed
    logic          deb_d_r;  // debounced level one cycle earlier
    logic          armed_r;  // button has been seen released since reset

    // Debounce: accept a new level only after DEBOUNCE_CYC disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= {DW{1'b0}};
        deb_r <= 1'b0;
      end else if (btn_lvl_s[gi] != deb_r) begin
        if (cnt_r == DEB_LAST) begin
          cnt_r <= {DW{1'b0}};
          deb_r <= btn_lvl_s[gi];
        end else begin
          cnt_r <= cnt_r + DW'(1);
          deb_r <= deb_r;
        end
      end else begin
        cnt_r <= {DW{1'b0}};
        deb_r <= deb_r;
      end
    end

    // Edge history and arming. A button held through reset never looked
    // released, so its eventual debounced rise must not count as a press;
    // it arms only once a genuine released sample has been observed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_d_r <= 1'b0;
        armed_r <= 1'b0;
      end else begin
        deb_d_r <= deb_r;
        if (flushed_s && !btn_lvl_s[gi]) begin
          armed_r <= 1'b1;
        end else begin
          armed_r <= armed_r;
        end
      end
    end

    assign press_s[gi] = deb_r & ~deb_d_r & armed_r;
  end

  logic ev_run_s;
  logic ev_step_s;
  logic ev_clr_s;

  assign ev_run_s  = press_s[BTN_RUN];
  assign ev_step_s = press_s[BTN_STEP];
  assign ev_clr_s  = press_s[BTN_CLR];

  // ---------------------------------------------------------------------------
  // Counter arithmetic
  // ---------------------------------------------------------------------------
  state_t        state_r;
  state_t        state_nx_s;
  logic [3:0]    led_r;
  logic          running_r;
  logic          tick_r;
  logic [PW-1:0] presc_r;
  logic          do_adv_s;
  logic          do_clr_s;
  logic [3:0]    adv_led_s;

`ifdef LED_SEQ_UPDOWN_EN
  logic dir_up_r;
  logic adv_up_s;

  // Ping-pong step: returns {next direction_up, next count}.
  function automatic logic [4:0] advance_f(input logic [3:0] cur, input logic up);
    logic [4:0] res;
    if (up) begin
      if (cur == 4'hF) begin
        res = {1'b0, 4'hE};
      end else begin
        res = {1'b1, cur + 4'h1};
      end
    end else begin
      if (cur == 4'h0) begin
        res = {1'b1, 4'h1};
      end else begin
        res = {1'b0, cur - 4'h1};
      end
    end
    return res;
  endfunction

  // Next count and direction if an advance is taken this cycle.
  always_comb begin
    {adv_up_s, adv_led_s} = advance_f(led_r, dir_up_r);
  end

  // Direction register: cleared back to up by clear, flipped by advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_up_r <= 1'b1;
    end else if (do_clr_s) begin
      dir_up_r <= 1'b1;
    end else if (do_adv_s) begin
      dir_up_r <= adv_up_s;
    end else begin
      dir_up_r <= dir_up_r;
    end
  end
`else
  // Plain modulo-16 increment if an advance is taken this cycle.
  always_comb begin
    adv_led_s = led_r + 4'h1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Event decode: priority clr > run > step, lower events dropped
  // ---------------------------------------------------------------------------
  // Decide next state and whether the count advances or clears this cycle.
  always_comb begin
    state_nx_s = state_r;
    do_adv_s   = 1'b0;
    do_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ev_clr_s) begin
          do_clr_s = 1'b1;
        end else if (ev_run_s) begin
          state_nx_s = ST_RUN;
        end else if (ev_step_s) begin
          do_adv_s   = 1'b1;
          state_nx_s = ST_PAUSE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ev_clr_s) begin
          // Clear wins over a coincident tick: no advance.
          do_clr_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (ev_run_s) begin
          // A tick landing on the pause press still counts.
          do_adv_s   = tick_r;
          state_nx_s = ST_PAUSE;
        end else begin
          do_adv_s   = tick_r;
          state_nx_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev_clr_s) begin
          do_clr_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (ev_run_s) begin
          state_nx_s = ST_RUN;
        end else if (ev_step_s) begin
          do_adv_s   = 1'b1;
          state_nx_s = ST_PAUSE;
        end else begin
          state_nx_s = ST_PAUSE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State machine with registered outputs and prescaler
  // ---------------------------------------------------------------------------
  // State, count, running flag and tick. The tick flag is registered one
  // cycle ahead so that it is high exactly while the prescaler sits at
  // TICK_DIV-1; the prescaler only runs while staying in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      led_r     <= 4'h0;
      running_r <= 1'b0;
      tick_r    <= 1'b0;
      presc_r   <= {PW{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      running_r <= (state_nx_s == ST_RUN);

      if (do_clr_s) begin
        led_r <= 4'h0;
      end else if (do_adv_s) begin
        led_r <= adv_led_s;
      end else begin
        led_r <= led_r;
      end

      if ((state_r == ST_RUN) && (state_nx_s == ST_RUN)) begin
        if (presc_r == PRESC_LAST) begin
          presc_r <= {PW{1'b0}};
        end else begin
          presc_r <= presc_r + PW'(1);
        end
        tick_r <= (presc_r == PRESC_PRE);
      end else begin
        presc_r <= {PW{1'b0}};
        tick_r  <= 1'b0;
      end
    end
  end

  assign led     = led_r;
  assign running = running_r;
  assign tick    = tick_r;

endmodule

// File: doc/led_count_sequencer.md
LED_COUNT_SEQUENCER -- requirements
Module: led_count_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 12000000, clk cycles per count step in RUN (1 Hz at 12 MHz); legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYC, default 120000, stable cycles required before a button level is accepted (10 ms at 12 MHz); legal range >= 1.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_run_n  input  1  raw run/pause button, active-low, asynchronous to clk.
REQ-006 btn_step_n  input  1  raw single-step button, active-low, asynchronous to clk.
REQ-007 btn_clr_n  input  1  raw clear button, active-low, asynchronous to clk.
REQ-008 led  output  4  current count value, registered.
REQ-009 running  output  1  high while FSM is in RUN, registered.
REQ-010 tick  output  1  one-cycle pulse marking a RUN count step, registered.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then be inverted to an active-high level.
REQ-012 Debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles; any reversion restarts that count.
REQ-013 A press event SHALL be a one-cycle pulse on a 0->1 debounced transition, asserted DEBOUNCE_CYC+2 to DEBOUNCE_CYC+3 cycles after the raw edge; releases generate no event.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE; running = (state == RUN).
REQ-015 Event priority within one cycle SHALL be clr > run > step; lower-priority events in the same cycle are discarded.
REQ-016 IDLE: run -> RUN; step -> advance once, go to PAUSE; clr -> stay IDLE, led=0.
REQ-017 RUN: run -> PAUSE; clr -> IDLE, led=0; step ignored.
REQ-018 PAUSE: run -> RUN; step -> advance once, stay PAUSE; clr -> IDLE, led=0.
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 only in RUN and be held at 0 in IDLE and PAUSE; tick SHALL be high for the single cycle in which the prescaler equals TICK_DIV-1, then the prescaler returns to 0.
REQ-020 First tick after entering RUN SHALL occur TICK_DIV cycles after the entry edge; subsequent ticks every TICK_DIV cycles.
REQ-021 led SHALL advance on the clock edge that ends a tick cycle, i.e. the new value is visible the cycle after tick.
REQ-022 Tick coincident with run event in RUN: advance SHALL apply and FSM SHALL enter PAUSE; tick coincident with clr: clr wins, led=0, no advance.
REQ-023 Advance arithmetic is 4-bit; wrap behaviour per Configuration.

Reset
REQ-024 On rst high, immediately and independent of clk: state=IDLE, led=4'h0, running=0, tick=0, prescaler=0, debounce counters=0, debounced levels=0 (released), synchronizer flops=released, direction=up.
REQ-025 Reset asserted mid-RUN SHALL abort the step; no event or tick SHALL be generated on the first cycle after rst deasserts, even if a button is held.

Configuration
REQ-026 Macro LED_SEQ_UPDOWN_EN defined: advance ping-pongs; counting up, 15 -> 14 and direction flips to down; counting down, 0 -> 1 and direction flips to up; clr and rst restore direction up.
REQ-027 LED_SEQ_UPDOWN_EN undefined: advance is always led+1 modulo 16 (15 -> 0); no direction register exists.

Verification (TICK_DIV=4, DEBOUNCE_CYC=3)
REQ-028 Reset then run pressed and held 10 cycles -> one event, running=1, tick every 4 cycles, led 0,1,2,3 after ticks 1..3.
REQ-029 btn_step_n glitches low 2 cycles, high 1, low 2 -> no event, led stays 0, FSM stays IDLE.
REQ-030 PAUSE at led=15, step press -> led=0 (macro off) / led=14 (macro on).
REQ-031 RUN, run and clr pressed simultaneously -> IDLE, led=0, running=0, no tick.
REQ-032 RUN at led=5, rst pulsed 1 cycle with run button held -> led=0, IDLE, no event after release of rst until button released and re-pressed.
REQ-033 Macro on, 20 RUN ticks from 0 -> led sequence 1..15, 14, 13, 12, 11, 10.
